// File: rtl/down_counter_timer.sv
// Loadable down-counter / countdown timer with valid/ready load and one-cycle done pulse.
// Optional periodic mode: define DOWN_COUNTER_AUTO_RELOAD_EN to reload the last start value.
module down_counter_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             abort,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t state;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            out        <= '0;
            zero       <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload     <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid && load_ready) begin
                        out        <= load_value;
                        zero       <= (load_value == '0);
                        load_ready <= 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                        reload     <= load_value;
`endif
                        if (load_value != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // abort takes priority, including over the terminal decrement
                    if (abort) begin
                        state      <= IDLE;
                        out        <= '0;
                        zero       <= 1'b1;
                        busy       <= 1'b0;
                        load_ready <= 1'b1;
                    end else if (enable) begin
                        if (out == ONE) begin
                            done <= 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                            // RUN is only entered with a non-zero reload value
                            out  <= reload;
                            zero <= 1'b0;
`else
                            state <= DONE;
                            out   <= '0;
                            zero  <= 1'b1;
                            busy  <= 1'b0;
`endif
                        end else begin
                            out  <= out - ONE;
                            zero <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    out        <= '0;
                    zero       <= 1'b1;
                    load_ready <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    out        <= '0;
                    zero       <= 1'b1;
                    busy       <= 1'b0;
                    load_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
